// File: rtl/imem_pkg.sv
// Shared parameters and state encoding for the boot-time
// instruction-memory loader.
package imem_pkg;

    localparam int IMEM_ADDR_WIDTH = 5;
    localparam int IMEM_DATA_WIDTH = 16;
    localparam int IMEM_WORDS      = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } imem_state_e;

    function automatic logic len_bad(
        input logic [7:0] n,
        input int         words
    );
        return (n == 8'd0) || (int'(n) > words);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Receives a length/data/checksum byte stream and writes it into
// instruction memory, holding the CPU in reset until a good load.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = IMEM_DATA_WIDTH,
    parameter int WORDS      = IMEM_WORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_reset_n
);

    imem_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            chk_q, chk_d;
    logic [7:0]            hi_q, hi_d;
    logic                  accept;
    logic                  last_word;

    assign accept    = rx_valid && rx_ready;
    assign last_word = (32'(idx_q) + 32'd1) >= 32'(len_q);

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        len_d       = len_q;
        chk_d       = chk_q;
        hi_d        = hi_q;
        rx_ready    = 1'b0;
        mem_we      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        cpu_reset_n = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN;
                    chk_d   = 8'd0;
                end
            end
            S_LEN: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    len_d   = rx_data;
                    chk_d   = chk_q ^ rx_data;
                    idx_d   = '0;
                    state_d = len_bad(rx_data, WORDS) ? S_ERR : S_HI;
                end
            end
            S_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    hi_d    = rx_data;
                    chk_d   = chk_q ^ rx_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    chk_d   = chk_q ^ rx_data;
                    // Latch the write bundle so it stays put outside WRITE.
                    addr_d  = idx_q;
                    wdata_d = DATA_WIDTH'({hi_q, rx_data});
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                if (last_word) begin
                    state_d = S_CHK;
                end else begin
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    state_d = S_HI;
                end
            end
            S_CHK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (accept) begin
                    state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                cpu_reset_n = 1'b1;
                if (start) begin
                    state_d = S_LEN;
                    chk_d   = 8'd0;
                end
            end
            S_ERR: begin
                error = 1'b1;
                if (start) begin
                    state_d = S_LEN;
                    chk_d   = 8'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= 8'd0;
            chk_q   <= 8'd0;
            hi_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            len_q   <= len_d;
            chk_q   <= chk_d;
            hi_q    <= hi_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a stream-level reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_reset_n;

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(16),
        .WORDS(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .busy(busy),
        .done(done),
        .error(error),
        .cpu_reset_n(cpu_reset_n)
    );

    int          checks = 0;
    int          failures = 0;
    int          consumed = 0;
    int          nwr = 0;
    logic [7:0]  stream[$];
    logic [4:0]  exp_a[$];
    logic [15:0] exp_d[$];
    logic [15:0] obs[0:31];
    bit          exp_len_ok;
    bit          exp_ok;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Outputs depend only on registered state, so negedge is stable.
    always @(negedge clk) begin
        logic [4:0]  ea;
        logic [15:0] ed;
        if (mem_we) begin
            if (exp_a.size() == 0) begin
                chk("unexpected_we", 1, 0);
            end else begin
                ea = exp_a.pop_front();
                ed = exp_d.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(ea));
                chk("wr_data", 32'(mem_wdata), 32'(ed));
            end
            obs[mem_addr] = mem_wdata;
            nwr++;
            chk("ready_in_write", 32'(rx_ready), 0);
            chk("busy_in_write", 32'(busy), 1);
        end
        if (done !== 1'b1) chk("cpu_held", 32'(cpu_reset_n), 0);
        if (done && error) chk("done_and_error", 1, 0);
    end

    // Reference: length, data word pairs, XOR of everything before CHK.
    task automatic build_expect();
        int         n;
        logic [7:0] x;
        n = int'(stream[0]);
        exp_len_ok = (n >= 1) && (n <= 32);
        exp_ok = 1'b0;
        if (!exp_len_ok) return;
        x = 8'd0;
        for (int i = 0; i <= 2 * n; i++) x = x ^ stream[i];
        for (int i = 0; i < n; i++) begin
            exp_a.push_back(5'(i));
            exp_d.push_back({stream[1 + 2 * i], stream[2 + 2 * i]});
        end
        exp_ok = (stream[2 * n + 1] == x);
    endtask

    task automatic make_stream(input int n, input bit corrupt);
        logic [7:0] x;
        logic [7:0] b;
        stream.delete();
        stream.push_back(8'(n));
        if (n < 1 || n > 32) return;
        x = 8'(n);
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
            x = x ^ b;
        end
        if (corrupt) stream.push_back(x ^ 8'($urandom_range(1, 255)));
        else stream.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int gaps;
        bit acc;
        gaps = $urandom_range(0, 3);
        acc = 1'b0;
        repeat (gaps) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            start    = ($urandom_range(0, 3) == 0);
        end
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            start    = 1'b0;
            rx_valid = 1'b1;
            rx_data  = b;
            if (rx_ready) begin
                @(posedge clk);
                acc = 1'b1;
                consumed++;
            end
        end
        if (!acc) chk("byte_timeout", 0, 1);
    endtask

    task automatic do_start();
        repeat (2) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_done_clr", 32'(done), 0);
        chk("start_err_clr", 32'(error), 0);
    endtask

    task automatic run_load();
        int t;
        build_expect();
        consumed = 0;
        do_start();
        foreach (stream[i]) send_byte(stream[i]);
        #1;
        rx_valid = 1'b0;
        if (!exp_len_ok) chk("badlen_err_next", 32'(error), 1);
        t = 0;
        while (!(done || error) && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("end_done", 32'(done), 32'(exp_ok));
        chk("end_error", 32'(error), 32'(!exp_ok));
        chk("end_cpu_rst_n", 32'(cpu_reset_n), 32'(exp_ok));
        chk("end_busy", 32'(busy), 0);
        chk("writes_left", 32'(exp_a.size()), 0);
        chk("bytes_consumed", 32'(consumed), 32'(stream.size()));
        repeat (3) @(posedge clk);
        #1;
        chk("hold_cpu_rst_n", 32'(cpu_reset_n), 32'(exp_ok));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(rx_ready), 0);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_cpu"}, 32'(cpu_reset_n), 0);
    endtask

    task automatic good_stream();
        stream.delete();
        stream.push_back(8'h02);
        stream.push_back(8'h12);
        stream.push_back(8'h34);
        stream.push_back(8'hAB);
        stream.push_back(8'hCD);
        stream.push_back(8'h42);
    endtask

    initial begin
        int base;
        int t;
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int i = 0; i < 32; i++) obs[i] = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        good_stream();
        build_expect();
        chk("model_good_ok", 32'(exp_ok), 1);
        chk("model_wd1", 32'(exp_d[1]), 32'h0000ABCD);
        exp_a.delete();
        exp_d.delete();
        run_load();
        chk("good_word0", 32'(obs[0]), 32'h1234);
        chk("good_word1", 32'(obs[1]), 32'hABCD);
        chk("good_done", 32'(done), 1);

        good_stream();
        stream[5] = 8'h43;
        obs[0] = 16'h0;
        obs[1] = 16'h0;
        run_load();
        chk("badchk_word0", 32'(obs[0]), 32'h1234);
        chk("badchk_word1", 32'(obs[1]), 32'hABCD);
        chk("badchk_error", 32'(error), 1);

        base = nwr;
        make_stream(8'h21, 1'b0);
        run_load();
        make_stream(0, 1'b0);
        run_load();
        chk("badlen_no_we", 32'(nwr - base), 0);

        base = nwr;
        make_stream(32, 1'b0);
        run_load();
        chk("full_writes", 32'(nwr - base), 32);
        chk("full_done", 32'(done), 1);

        for (int k = 0; k < 10; k++) begin
            int n;
            if ($urandom_range(0, 7) == 0) n = $urandom_range(33, 255);
            else n = $urandom_range(1, 32);
            make_stream(n, bit'($urandom_range(0, 1)));
            run_load();
        end

        make_stream(4, 1'b0);
        build_expect();
        base = nwr;
        do_start();
        for (int i = 0; i < 7; i++) send_byte(stream[i]);
        #1;
        rx_valid = 1'b0;
        t = 0;
        while (nwr < base + 3 && t < 10) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("mid_third_write", 32'(nwr - base), 3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        chk("midrst_pending", 32'(exp_a.size()), 1);
        exp_a.delete();
        exp_d.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_more_we", 32'(nwr - base), 3);
        chk("midrst_idle_busy", 32'(busy), 0);

        good_stream();
        obs[0] = 16'h0;
        obs[1] = 16'h0;
        run_load();
        chk("post_rst_word0", 32'(obs[0]), 32'h1234);
        chk("post_rst_word1", 32'(obs[1]), 32'hABCD);
        chk("post_rst_done", 32'(done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
